// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared encodings for the game-play sequencer: results-screen
//                phase codes, note types, judge FSM states and the default
//                hit-window length.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Phase reported to the results screen
    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_DONE = 2'd2;

    // Note types as delivered by chart playback
    localparam logic NOTE_DON = 1'b0;
    localparam logic NOTE_KA  = 1'b1;

    // Default hit-window length in clk cycles
    localparam int DEFAULT_WINDOW = 8;

    // Internal judge FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } judge_state_t;

    // Increment that sticks at the top of the 8-bit range
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pad_edge
//  Description : Registered rising-edge detector for one drum pad. The pad
//                history register updates every cycle, so a held pad only
//                reports its first cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_pad,
    output logic o_rise
);

    logic r_pad_q;

    // Remember last cycle's pad level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pad_q <= 1'b0;
        end else begin
            r_pad_q <= i_pad;
        end
    end

    assign o_rise = i_pad & ~r_pad_q;

endmodule
`default_nettype wire

// File: rtl/note_judge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : note_judge_ctrl
//  Description : Game-play sequencer. Judges each arriving note as hit or
//                miss inside a WINDOW-cycle timing window, drives the
//                score/combo counter pulses, keeps a one-entry pending note
//                buffer and the hit/miss totals for the results screen.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_judge_ctrl
    import game_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int TW     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       note_valid,
    input  logic       note_type,
    input  logic       hit_don,
    input  logic       hit_ka,
    input  logic       song_end,
    output logic       increase_score,
    output logic       decrease_score,
    output logic       score_reset,
    output logic [1:0] game_state,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic       overflow
);

    localparam logic [TW-1:0] c_TIMER_LOAD = TW'(WINDOW - 1);
    localparam logic [TW-1:0] c_TIMER_ONE  = TW'(1);

    judge_state_t  r_state;
    logic [1:0]    r_game_state;
    logic [TW-1:0] r_timer;
    logic          r_note_type;
    logic          r_pend_valid;
    logic          r_pend_type;
    logic          r_song_end;
    logic          r_inc;
    logic          r_dec;
    logic          r_score_reset;
    logic [7:0]    r_hit;
    logic [7:0]    r_miss;
    logic          r_overflow;

    logic w_don_edge;
    logic w_ka_edge;
    logic w_in_judge;
    logic w_hit;
    logic w_wrong;
    logic w_miss;
    logic w_resolve;

    pad_edge u_don_edge (
        .clk    (clk),
        .resetn (resetn),
        .i_pad  (hit_don),
        .o_rise (w_don_edge)
    );

    pad_edge u_ka_edge (
        .clk    (clk),
        .resetn (resetn),
        .i_pad  (hit_ka),
        .o_rise (w_ka_edge)
    );

    // Judgement of the note under the window this cycle, in priority order:
    // matching single edge, any other edge, then window expiry.
    assign w_in_judge = (r_state == ST_JUDGE);
    assign w_hit      = w_in_judge & (w_don_edge ^ w_ka_edge) & (w_ka_edge == r_note_type);
    assign w_wrong    = w_in_judge & (w_don_edge | w_ka_edge) & ~w_hit;
    assign w_miss     = w_in_judge & ~(w_don_edge | w_ka_edge) & (r_timer == '0);
    assign w_resolve  = w_hit | w_wrong | w_miss;

    // Judge FSM with registered pulses, counters, pending buffer and phase
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_game_state  <= GS_IDLE;
            r_timer       <= '0;
            r_note_type   <= NOTE_DON;
            r_pend_valid  <= 1'b0;
            r_pend_type   <= NOTE_DON;
            r_song_end    <= 1'b0;
            r_inc         <= 1'b0;
            r_dec         <= 1'b0;
            r_score_reset <= 1'b0;
            r_hit         <= 8'd0;
            r_miss        <= 8'd0;
            r_overflow    <= 1'b0;
        end else begin
            // Pulses only ever come out of JUDGE, so they are exclusive
            // with each other and with score_reset.
            r_inc         <= w_hit;
            r_dec         <= w_wrong | w_miss;
            r_score_reset <= 1'b0;
            if (w_hit) begin
                r_hit <= sat_inc(r_hit);
            end
            if (w_wrong | w_miss) begin
                r_miss <= sat_inc(r_miss);
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_CLEAR;
                        r_game_state <= GS_PLAY;
                    end
                end

                ST_CLEAR: begin
                    r_score_reset <= 1'b1;
                    r_hit         <= 8'd0;
                    r_miss        <= 8'd0;
                    r_overflow    <= 1'b0;
                    r_pend_valid  <= 1'b0;
                    r_pend_type   <= NOTE_DON;
                    // A song_end arriving during the clear is still kept
                    r_song_end    <= song_end;
                    r_state       <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (song_end) begin
                        r_song_end <= 1'b1;
                    end
                    if (note_valid) begin
                        r_note_type <= note_type;
                        r_timer     <= c_TIMER_LOAD;
                        r_state     <= ST_JUDGE;
                    end else if (r_song_end) begin
                        r_state      <= ST_DONE;
                        r_game_state <= GS_DONE;
                    end
                end

                ST_JUDGE: begin
                    if (song_end) begin
                        r_song_end <= 1'b1;
                    end
                    // A note arriving while the buffer is full is lost
                    if (note_valid && r_pend_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_resolve) begin
                        if (r_pend_valid) begin
                            r_note_type  <= r_pend_type;
                            r_timer      <= c_TIMER_LOAD;
                            r_pend_valid <= 1'b0;
                        end else if (note_valid) begin
                            r_note_type <= note_type;
                            r_timer     <= c_TIMER_LOAD;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_timer <= r_timer - c_TIMER_ONE;
                        if (note_valid && !r_pend_valid) begin
                            r_pend_valid <= 1'b1;
                            r_pend_type  <= note_type;
                        end
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_CLEAR;
                        r_game_state <= GS_PLAY;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_game_state <= GS_IDLE;
                end
            endcase
        end
    end

    assign increase_score = r_inc;
    assign decrease_score = r_dec;
    assign score_reset    = r_score_reset;
    assign game_state     = r_game_state;
    assign hit_count      = r_hit;
    assign miss_count     = r_miss;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_note_judge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_judge_ctrl
//  Description : Self-checking bench for note_judge_ctrl (WINDOW = 4). A
//                note-queue model predicts every output each cycle; directed
//                sequences pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_judge_ctrl;

    localparam int W = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_DONE = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       note_valid = 1'b0;
    logic       note_type = 1'b0;
    logic       hit_don = 1'b0;
    logic       hit_ka = 1'b0;
    logic       song_end = 1'b0;
    logic       increase_score;
    logic       decrease_score;
    logic       score_reset;
    logic [1:0] game_state;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: phase, notes awaiting judgement (head = being judged)
    int m_phase;
    bit m_clearing;
    bit notes[$];
    int m_left;
    bit m_ended;
    bit m_prev_don;
    bit m_prev_ka;
    // Model expected outputs
    int e_inc, e_dec, e_rst, e_gs, e_hit, e_miss, e_ovf;

    note_judge_ctrl #(.WINDOW(W), .TW(3)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .note_valid     (note_valid),
        .note_type      (note_type),
        .hit_don        (hit_don),
        .hit_ka         (hit_ka),
        .song_end       (song_end),
        .increase_score (increase_score),
        .decrease_score (decrease_score),
        .score_reset    (score_reset),
        .game_state     (game_state),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_clearing = 0; notes.delete(); m_left = 0;
        m_ended = 0; m_prev_don = 0; m_prev_ka = 0;
        e_inc = 0; e_dec = 0; e_rst = 0; e_gs = 0; e_hit = 0; e_miss = 0; e_ovf = 0;
    endtask

    // One clock of game rules, applied to the inputs the DUT just sampled
    task automatic model_step();
        bit de, ke, hit, wrong, miss, old_end;
        de = hit_don && !m_prev_don;
        ke = hit_ka && !m_prev_ka;
        e_inc = 0; e_dec = 0; e_rst = 0;
        if (m_clearing) begin
            e_rst = 1; e_hit = 0; e_miss = 0; e_ovf = 0;
            notes.delete(); m_ended = song_end; m_clearing = 0;
        end else if (m_phase != PH_PLAY) begin
            if (start) begin
                m_clearing = 1; m_phase = PH_PLAY; e_gs = 1;
            end
        end else if (notes.size() == 0) begin
            old_end = m_ended;
            m_ended = m_ended | song_end;
            if (note_valid) begin
                notes.push_back(note_type); m_left = W;
            end else if (old_end) begin
                m_phase = PH_DONE; e_gs = 2;
            end
        end else begin
            m_ended = m_ended | song_end;
            hit   = (de ^ ke) && (ke == notes[0]);
            wrong = (de || ke) && !hit;
            miss  = !de && !ke && (m_left == 1);
            if (note_valid) begin
                if (notes.size() >= 2) e_ovf = 1;
                else notes.push_back(note_type);
            end
            if (hit) begin
                e_inc = 1; e_hit = (e_hit >= 255) ? 255 : e_hit + 1;
            end
            if (wrong || miss) begin
                e_dec = 1; e_miss = (e_miss >= 255) ? 255 : e_miss + 1;
            end
            if (hit || wrong || miss) begin
                void'(notes.pop_front()); m_left = W;
            end else begin
                m_left--;
            end
        end
        m_prev_don = hit_don;
        m_prev_ka  = hit_ka;
    endtask

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("increase_score", int'(increase_score), e_inc);
            chk("decrease_score", int'(decrease_score), e_dec);
            chk("score_reset",    int'(score_reset),    e_rst);
            chk("game_state",     int'(game_state),     e_gs);
            chk("hit_count",      int'(hit_count),      e_hit);
            chk("miss_count",     int'(miss_count),     e_miss);
            chk("overflow",       int'(overflow),       e_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #1;
        resetn = 0; start = 0; note_valid = 0; note_type = 0;
        hit_don = 0; hit_ka = 0; song_end = 0;
        model_reset();
        #1;
        chk("rst_game_state", int'(game_state), 0);
        chk("rst_pulses", int'({increase_score, decrease_score, score_reset}), 0);
        chk("rst_counts", int'({hit_count, miss_count}), 0);
        chk("rst_overflow", int'(overflow), 0);
        tick();
        resetn = 1;
    endtask

    initial begin
        int pulses;
        bit reached;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1;
        chk_en = 1;

        // Reset in the middle of a judgement
        start = 1; tick(); start = 0; tick();
        note_valid = 1; note_type = 1; tick(); note_valid = 0; tick();
        apply_reset();

        // Clean hit two cycles after the note arrives
        start = 1; tick(); start = 0; tick();
        chk("score_reset_pulse", int'(score_reset), 1);
        chk("play_state", int'(game_state), 1);
        note_valid = 1; note_type = 0; tick(); note_valid = 0; tick();
        hit_don = 1; tick();
        chk("hit_pulse", int'(increase_score), 1);
        chk("hit_count_1", int'(hit_count), 1);
        hit_don = 0; tick();
        chk("hit_pulse_single", int'(increase_score), 0);

        // Ka note ignored: miss pulse exactly 5 cycles after note_valid
        note_valid = 1; note_type = 1; tick(); note_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("miss_timing", int'(decrease_score), (k == 4) ? 1 : 0);
        end
        chk("miss_count_1", int'(miss_count), 1);

        // Wrong pad, then both pads together
        note_valid = 1; note_type = 0; tick(); note_valid = 0;
        hit_ka = 1; tick(); hit_ka = 0; tick();
        note_valid = 1; note_type = 1; tick(); note_valid = 0;
        hit_don = 1; hit_ka = 1; tick(); hit_don = 0; hit_ka = 0; tick();
        chk("wrong_miss_count", int'(miss_count), 3);
        chk("wrong_hit_count", int'(hit_count), 1);

        // Three back-to-back notes: one judged, one pending, one dropped
        pulses = 0;
        note_valid = 1; note_type = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); pulses += int'(increase_score) + int'(decrease_score);
        end
        note_valid = 0;
        chk("overflow_set", int'(overflow), 1);
        for (int k = 0; k < 12; k++) begin
            tick(); pulses += int'(increase_score) + int'(decrease_score);
        end
        chk("two_judgements", pulses, 2);
        chk("overflow_miss_count", int'(miss_count), 5);

        // Randomized play, including restarts and song ends
        for (int k = 0; k < 4000; k++) begin
            note_valid = ($urandom % 4 == 0);
            note_type  = 1'($urandom);
            if ($urandom % 3 == 0) hit_don = 1'($urandom);
            if ($urandom % 3 == 0) hit_ka  = 1'($urandom);
            song_end   = ($urandom % 80 == 0);
            start      = ($urandom % 12 == 0);
            tick();
        end
        apply_reset();

        // Saturation, then song end behind two in-flight notes
        start = 1; tick(); start = 0; tick();
        for (int k = 0; k < 256; k++) begin
            note_valid = 1; note_type = 0; tick(); note_valid = 0;
            hit_don = 1; tick(); hit_don = 0; tick();
        end
        chk("hit_saturated", int'(hit_count), 255);
        note_valid = 1; note_type = 0; tick();
        note_valid = 1; note_type = 1; song_end = 1; tick();
        note_valid = 0; song_end = 0;
        repeat (4) tick();
        chk("still_playing", int'(game_state), 1);
        reached = 0;
        for (int k = 0; k < 20 && !reached; k++) begin
            tick();
            if (game_state == 2'd2) reached = 1;
        end
        chk("reached_done", int'(reached), 1);
        chk("done_miss_count", int'(miss_count), 2);
        start = 1; tick(); start = 0; tick();
        chk("restart_hits", int'(hit_count), 0);
        chk("restart_misses", int'(miss_count), 0);
        chk("restart_state", int'(game_state), 1);
        tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_judge_ctrl.md
Name: note_judge_ctrl

Overview:
- Game-play sequencer that drives the score and combo counters.
- Takes note-arrival events from the chart playback logic and drum-pad inputs (don/ka), and judges each note as a hit or a miss inside a programmable timing window.
- Emits single-cycle increase_score/decrease_score pulses to the counters and a score_reset pulse when a song starts.
- Also tracks the game phase (idle / playing / done), hit totals and miss totals for the results screen.

Parameters:
- WINDOW, 8: hit-window length in clk cycles; must be >= 2.
- TW, 4: timer width; must satisfy 2^TW >= WINDOW.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- start  in  1  level; begins a song from IDLE or DONE
- note_valid  in  1  one-cycle pulse; a note has entered the hit window
- note_type  in  1  type of the note, valid with note_valid; 0 = don, 1 = ka
- hit_don  in  1  don pad, raw level
- hit_ka  in  1  ka pad, raw level
- song_end  in  1  pulse; chart playback finished
- increase_score  out  1  one-cycle pulse to the score/combo counters
- decrease_score  out  1  one-cycle pulse to the score/combo counters
- score_reset  out  1  one-cycle pulse to the score counter
- game_state  out  2  0 = IDLE, 1 = PLAY, 2 = DONE
- hit_count  out  8  unsigned, saturating
- miss_count  out  8  unsigned, saturating
- overflow  out  1  sticky; a note was dropped

Behaviour:
- Reset: one clock; resetn is asynchronous and active-low. While resetn is low:
  - FSM goes to IDLE.
  - All outputs, the timer, the pending buffer, the song_end latch and the edge-detect registers are cleared to 0.
  - Reset mid-song abandons the current note with no pulse.
- Registered outputs: all outputs are registered. A judgement made in cycle N appears as a pulse in cycle N+1.
- Edge detection:
  - Registers hd_q/hk_q update every cycle in every state.
  - don_edge = hit_don & ~hd_q; ka_edge = hit_ka & ~hk_q.
  - Held pads never re-trigger.
- FSM states: IDLE, CLEAR, WAIT, JUDGE, DONE.
- IDLE: when start = 1, go to CLEAR.
- CLEAR (one cycle):
  - score_reset pulses.
  - hit_count, miss_count, overflow, the pending buffer and the song_end latch clear.
  - Next state is WAIT.
- WAIT:
  - On note_valid: latch note_type, load timer = WINDOW-1, go to JUDGE.
  - Pad edges in WAIT are ignored (no penalty).
  - If the song_end latch is set and note_valid = 0, go to DONE.
- JUDGE, resolved in priority order each cycle:
  1. Exactly one edge, matching the note type: hit. Pulse increase_score; hit_count += 1.
  2. Any other edge (wrong pad, or both pads in the same cycle): wrong. Pulse decrease_score; miss_count += 1.
  3. No edge and timer == 0: miss. Pulse decrease_score; miss_count += 1.
  4. Otherwise: timer decrements and the FSM stays in JUDGE.
- After a JUDGE resolution:
  - If pending is set, load the pending type, reload timer = WINDOW-1, clear pending and stay in JUDGE.
  - Otherwise go to WAIT.
  - A hit is therefore accepted in any of the WINDOW JUDGE cycles.
- Pending buffer (one entry):
  - note_valid in JUDGE with pending empty: store note_type in pending.
  - note_valid in JUDGE with pending full: drop the note and set overflow. The dropped note produces no pulse and is not counted.
  - note_valid in the same cycle as a resolution with pending empty: the new note goes to pending and is loaded immediately.
- song_end:
  - Latched in any PLAY substate.
  - DONE is entered only from WAIT with no pending note, so in-flight notes are always judged first.
- DONE:
  - Holds the counts; pad edges are ignored.
  - start = 1 goes to CLEAR.
  - start held high through DONE restarts immediately.
- Pulse exclusivity: at most one of increase_score/decrease_score is high in any cycle. score_reset never coincides with either.
- Count saturation: hit_count and miss_count saturate at 255. The pulses are still emitted at saturation.
- game_state mapping: IDLE = 0; CLEAR, WAIT and JUDGE = 1; DONE = 2.
- start outside IDLE/DONE is ignored.

Decomposition:
- Shared package (game_pkg):
  - game_state encodings GS_IDLE/GS_PLAY/GS_DONE.
  - Note-type constants NOTE_DON = 0 and NOTE_KA = 1.
  - Internal FSM state encoding.
  - Default WINDOW.
- Sub-module pad_edge: a single instance per pad holding the registered rising-edge detector, reused later by the menu logic.
- Judge FSM, timer, pending buffer and saturating counters stay in this module.

Test Plan (WINDOW = 4):
- Reset mid-JUDGE (resetn low 1 cycle) -> game_state = 0, no pulse, counts 0, overflow 0.
- start, then note_valid (type 0) and don_edge 2 cycles later -> score_reset pulse 1 cycle after start; increase_score exactly 1 cycle; hit_count = 1; FSM back in WAIT.
- Note type 1 with no pad activity -> decrease_score pulses 5 cycles after note_valid; miss_count = 1.
- Note type 0, then hit_ka, then hit_don and hit_ka in the same cycle on the next note -> two decrease pulses, miss_count = 2, hit_count = 0.
- Three note_valid pulses 1 cycle apart while judging -> 2nd note queued in pending, 3rd dropped; overflow = 1; exactly 2 judgements issued.
- 256 hits, then song_end -> hit_count = 255; game_state = 2 only after the last pending note resolves; start -> counts cleared, game_state = 1.
